// File: rtl/imem_loader.sv
// imem_loader: framed, checksummed byte-stream loader that writes 19-bit words into instruction memory
// and holds the CPU in reset while a download is in progress.
module imem_loader #(
    parameter logic [7:0] HEADER = 8'hA5,
    parameter int ADDR_W = 12,
    parameter int WORD_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);
    typedef enum logic [3:0] {
        IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, W0, W1, W2, CHK, DONE, ERR
    } state_t;

    state_t            r_state;
    logic [7:0]        r_chk;
    logic [3:0]        r_hi;
    logic [11:0]       r_cnt;
    logic [ADDR_W-1:0] r_next;
    logic [2:0]        r_w0;
    logic [7:0]        r_w1;
    logic              w_acc;
    logic              w_hdr;
    logic              w_sum;

    assign w_acc = byte_valid && byte_ready;
    assign w_hdr = byte_data == HEADER;
    assign w_sum = r_state inside {ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, W0, W1, W2};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_chk      <= '0;
            r_hi       <= '0;
            r_cnt      <= '0;
            r_next     <= '0;
            r_w0       <= '0;
            r_w1       <= '0;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            byte_ready <= 1'b1;
            wr_en      <= 1'b0;
            if (w_acc && w_sum)
                r_chk <= r_chk ^ byte_data;
            if (w_acc) begin
                case (r_state)
                    IDLE, DONE, ERR: if (w_hdr) begin
                        r_state  <= ADDR_HI;
                        r_chk    <= '0;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                    end
                    ADDR_HI: begin
                        r_hi    <= byte_data[3:0];
                        r_state <= ADDR_LO;
                    end
                    ADDR_LO: begin
                        r_next  <= {r_hi, byte_data};
                        r_state <= CNT_HI;
                    end
                    CNT_HI: begin
                        r_hi    <= byte_data[3:0];
                        r_state <= CNT_LO;
                    end
                    CNT_LO: begin
                        r_cnt   <= {r_hi, byte_data};
                        r_state <= ({r_hi, byte_data} == 12'd0) ? CHK : W0;
                    end
                    W0: if (byte_data[7:3] != 5'd0) begin
                        r_state  <= ERR;
                        error    <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        r_w0    <= byte_data[2:0];
                        r_state <= W1;
                    end
                    W1: begin
                        r_w1    <= byte_data;
                        r_state <= W2;
                    end
                    W2: begin
                        // address wraps silently at the top of memory
                        wr_en   <= 1'b1;
                        wr_addr <= r_next;
                        wr_data <= {r_w0, r_w1, byte_data};
                        r_next  <= r_next + 1'b1;
                        r_cnt   <= r_cnt - 1'b1;
                        r_state <= (r_cnt == 12'd1) ? CHK : W0;
                    end
                    CHK: begin
                        r_state  <= (byte_data == r_chk) ? DONE : ERR;
                        done     <= byte_data == r_chk;
                        error    <= byte_data != r_chk;
                        cpu_hold <= 1'b0;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames with a write scoreboard; expected writes are queued as words are
// sent and popped when wr_en is observed.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [18:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  xs;
    logic [11:0] addr;
    logic [30:0] exp_q[$];

    imem_loader dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
            end else begin
                logic [30:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e[30:19]));
                check("wr_data", 32'(wr_data), 32'(e[18:0]));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        xs         = xs ^ b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic header(input logic [7:0] ah, input logic [7:0] al, input logic [7:0] ch,
                          input logic [7:0] cl);
        send(8'hA5);
        xs = 8'h00;
        send(ah); send(al); send(ch); send(cl);
        addr = {ah[3:0], al};
    endtask

    task automatic word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        exp_q.push_back({addr, b0[2:0], b1, b2});
        addr = addr + 12'd1;
        send(b0); send(b1);
        check("wr_en_before_w2", 32'(wr_en), 0);
        send(b2);
        check("wr_en_after_w2", 32'(wr_en), 1);
    endtask

    initial begin
        xs = 8'h00;
        addr = '0;
        #3;
        check("rst_ready", 32'(byte_ready), 0);
        check("rst_outs", 32'({wr_en, wr_addr, wr_data, cpu_hold, done, error}), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_before_edge", 32'(byte_ready), 0);
        @(posedge clk);
        #1;
        check("ready_after_edge", 32'(byte_ready), 1);

        // idle noise
        send(8'h00); send(8'hFF);
        check("noise_outs", 32'({wr_en, cpu_hold, done, error}), 0);

        // two words at 0x002, good checksum
        send(8'hA5);
        check("hold_on_header", 32'(cpu_hold), 1);
        xs = 8'h00;
        send(8'h00); send(8'h02); send(8'h00); send(8'h02);
        addr = 12'h002;
        word(8'h04, 8'h00, 8'h64);
        word(8'h01, 8'h00, 8'h66);
        check("pre_chk", 32'({cpu_hold, done, error}), 32'b100);
        send(xs);
        check("good_done", 32'({cpu_hold, done, error}), 32'b010);

        // header in DONE clears done, sets hold; then bad checksum
        send(8'hA5);
        check("hdr_in_done", 32'({cpu_hold, done}), 32'b10);
        xs = 8'h00;
        send(8'h00); send(8'h02); send(8'h00); send(8'h02);
        addr = 12'h002;
        word(8'h04, 8'h00, 8'h64);
        word(8'h01, 8'h00, 8'h66);
        send(xs ^ 8'h01);
        check("bad_chk", 32'({cpu_hold, done, error}), 32'b001);

        // address wrap; header in ERR clears error
        send(8'hA5);
        check("hdr_in_err", 32'({cpu_hold, error}), 32'b10);
        xs = 8'h00;
        send(8'h0F); send(8'hFF); send(8'h00); send(8'h02);
        addr = 12'hFFF;
        word(8'h00, 8'h00, 8'h01);
        word(8'h00, 8'h00, 8'h02);
        send(xs);
        check("wrap_done", 32'({cpu_hold, done, error}), 32'b010);

        // count zero, upper nibbles ignored but summed
        header(8'hF1, 8'h00, 8'hF0, 8'h00);
        check("cnt0_pre", 32'({cpu_hold, done}), 32'b10);
        send(xs);
        check("cnt0_done", 32'({cpu_hold, done, error}), 32'b010);

        // bad W0 on first word
        header(8'h00, 8'h10, 8'h00, 8'h02);
        send(8'h08);
        check("bad_w0", 32'({cpu_hold, done, error}), 32'b001);
        send(8'h00); send(8'h00);
        check("bad_w0_stays", 32'({wr_en, error}), 32'b01);

        // reset after W1
        header(8'h00, 8'h20, 8'h00, 8'h01);
        check("err_cleared", 32'({cpu_hold, error}), 32'b10);
        send(8'h01); send(8'h22);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 32'({byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(byte_ready), 1);
        send(8'h33);
        check("no_partial_write", 32'({wr_en, cpu_hold}), 0);

        // fresh frame after reset
        header(8'h00, 8'h30, 8'h00, 8'h01);
        word(8'h03, 8'h45, 8'h67);
        send(xs);
        check("fresh_done", 32'({cpu_hold, done, error}), 32'b010);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
